// File: rtl/ckey_led_pkg.sv
// Shared encodings for the DIP-switch / LED controller.
// Mode codes select how the debounced switch state is shown on the LEDs.
// LEDs and switches are both active-low, so "off"/"open" is a 1.
package ckey_led_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_INVERT = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  localparam logic LED_OFF = 1'b1;

endpackage

// File: rtl/ckey_debounce.sv
// One switch channel: 2-FF synchroniser, debounce counter, change pulse.
// Latency pin->db: 2+DEB_CNT cycles with CKEY_LED_DEBOUNCE_EN, else 2 cycles.
// No backpressure; db and chg are registered and update on the same edge.
module ckey_debounce
  import ckey_led_pkg::*;
#(
  parameter int DEB_CNT = 1000000,
  parameter int DEB_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic db,
  output logic chg
);

  // Reject a counter too narrow to reach DEB_CNT-1 at elaboration time.
  if (DEB_CNT < 1 || (DEB_W < 31 && (1 << DEB_W) <= DEB_CNT)) begin : g_bad_cfg
    $error("ckey_debounce: need DEB_CNT >= 1 and 2**DEB_W > DEB_CNT");
  end

  logic meta_q, meta_d;
  logic db_q,   db_d;
  logic chg_q,  chg_d;

`ifdef CKEY_LED_DEBOUNCE_EN
  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CNT - 1);

  logic             sync_q, sync_d;
  logic [DEB_W-1:0] cnt_q,  cnt_d;

  // Count while the synchronised input disagrees with db; accept on the last count.
  always_comb begin
    meta_d = pin;
    sync_d = meta_q;
    db_d   = db_q;
    chg_d  = 1'b0;
    cnt_d  = '0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync_q;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  // State registers; reset parks everything at "switch open" with an empty count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      db_q   <= 1'b1;
      chg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      db_q   <= db_d;
      chg_q  <= chg_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  // Without debouncing the second synchroniser stage is the db flop itself.
  always_comb begin
    meta_d = pin;
    db_d   = meta_q;
    chg_d  = meta_q ^ db_q;
  end

  // State registers; reset parks everything at "switch open".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      db_q   <= 1'b1;
      chg_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      db_q   <= db_d;
      chg_q  <= chg_d;
    end
  end
`endif

  assign db  = db_q;
  assign chg = chg_q;

endmodule

// File: rtl/ckey_led_ctrl.sv
// DIP switch to LED controller: per-channel debounce, 4 display modes (direct/invert/blink/toggle).
// Latency: led is registered one cycle after ckey_db/tog/blink phase; debounce gated by CKEY_LED_DEBOUNCE_EN.
// No backpressure; all outputs are free-running registers.
module ckey_led_ctrl
  import ckey_led_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DEB_CNT   = 1000000,
  parameter int DEB_W     = 20,
  parameter int BLINK_DIV = 12500000,
  parameter int BLINK_W   = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] ckey,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] ckey_db,
  output logic [N_CH-1:0] chg
);

  // Reject out-of-range channel counts or an undersized blink prescaler.
  if (N_CH < 1 || N_CH > 16 || BLINK_DIV < 1 ||
      (BLINK_W < 31 && (1 << BLINK_W) <= BLINK_DIV)) begin : g_bad_cfg
    $error("ckey_led_ctrl: bad N_CH or BLINK_DIV/BLINK_W");
  end

  localparam logic [BLINK_W-1:0] BC_LAST = BLINK_W'(BLINK_DIV - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ckey_debounce #(
      .DEB_CNT (DEB_CNT),
      .DEB_W   (DEB_W)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (ckey[i]),
      .db    (ckey_db[i]),
      .chg   (chg[i])
    );
  end

  logic [BLINK_W-1:0] bc_q,  bc_d;
  logic               ph_q,  ph_d;
  logic [N_CH-1:0]    tog_q, tog_d;
  logic [N_CH-1:0]    led_q, led_d;

  // Prescaler, toggle latches and output mux; latches run in every mode.
  always_comb begin
    bc_d = bc_q + BLINK_W'(1);
    ph_d = ph_q;
    if (bc_q == BC_LAST) begin
      bc_d = '0;
      ph_d = ~ph_q;
    end

    // A change pulse with db now low marks a switch closing.
    tog_d = tog_q ^ (chg & ~ckey_db);

    led_d = ckey_db;
    case (mode)
      MODE_DIRECT: led_d = ckey_db;
      MODE_INVERT: led_d = ~ckey_db;
      MODE_BLINK:  led_d = ckey_db | {N_CH{ph_q}};
      MODE_TOGGLE: led_d = tog_q;
      default:     led_d = ckey_db;
    endcase
  end

  // State registers; reset turns every LED and latch off and restarts the blink.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bc_q  <= '0;
      ph_q  <= 1'b0;
      tog_q <= {N_CH{LED_OFF}};
      led_q <= {N_CH{LED_OFF}};
    end else begin
      bc_q  <= bc_d;
      ph_q  <= ph_d;
      tog_q <= tog_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule
